// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_pkg
// Shared arithmetic definitions for the sequential divider:
//   - DIV_WIDTH_DEFAULT : default operand/result width
//   - div_state_t       : controller state encoding (IDLE / RUN / DONE)
//   - div_count_width   : helper returning the iteration counter width
// -----------------------------------------------------------------------------
package div_seq_pkg;

   localparam int DIV_WIDTH_DEFAULT = 8;

   typedef logic [1:0] div_state_t;

   localparam div_state_t ST_IDLE = 2'd0;
   localparam div_state_t ST_RUN  = 2'd1;
   localparam div_state_t ST_DONE = 2'd2;

   // The counter must hold the value N itself, hence N+1 distinct values.
   function automatic int div_count_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/div_seq_adder.sv
// -----------------------------------------------------------------------------
// div_seq_adder
// Parameterized ripple-carry adder, used by the divider as its trial
// subtractor (operand b pre-inverted, cin_i tied high).
// Ports:
//   a_i, b_i  in  W  addends
//   cin_i     in  1  carry in
//   sum_o     out W  a_i + b_i + cin_i (mod 2**W)
//   cout_o    out 1  carry out of the top bit
// -----------------------------------------------------------------------------
module div_seq_adder #(
   parameter int W = 9
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);

   logic [W:0] carry;

   assign carry[0] = cin_i;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_bit
         assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ carry[gi];
         assign carry[gi + 1] = (a_i[gi] & b_i[gi]) |
                                (a_i[gi] & carry[gi]) |
                                (b_i[gi] & carry[gi]);
      end
   endgenerate

   assign cout_o = carry[W];

endmodule

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Multi-cycle unsigned restoring divider. One quotient bit is resolved per
// RUN cycle; a zero divisor short-circuits straight to DONE.
// Ports:
//   clk          in  1  clock, rising edge
//   rst          in  1  synchronous active-high reset
//   start        in  1  request strobe, honoured only in IDLE
//   dividend     in  N  numerator, sampled with start
//   divisor      in  N  denominator, sampled with start
//   busy         out 1  high while not IDLE
//   done         out 1  one-cycle pulse, results valid
//   quotient     out N  result, held until next accepted start
//   remainder    out N  result, held until next accepted start
//   div_by_zero  out 1  result flag for a zero divisor
// -----------------------------------------------------------------------------
module div_seq
   import div_seq_pkg::*;
#(
   parameter int N = DIV_WIDTH_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int            CW         = div_count_width(N);
   localparam logic [CW-1:0] COUNT_LOAD = CW'(N);
   localparam logic [CW-1:0] COUNT_LAST = CW'(1);

   div_state_t    state_q, state_d;
   logic [N-1:0]  q_q, q_d;          // dividend shifting out / quotient shifting in
   logic [N:0]    r_q, r_d;          // partial remainder
   logic [N-1:0]  d_q, d_d;          // latched divisor
   logic [CW-1:0] count_q, count_d;
   logic [N-1:0]  quotient_q, quotient_d;
   logic [N-1:0]  remainder_q, remainder_d;
   logic          dbz_q, dbz_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [N:0]    shifted;
   logic [N:0]    sub_operand;
   logic [N:0]    trial;
   logic          no_borrow;

   // After a restore step the partial remainder is always below the divisor,
   // so its top bit never carries information into the next shift.
   logic          r_msb_unused;
   assign r_msb_unused = r_q[N];

   assign shifted     = {r_q[N-1:0], q_q[N-1]};
   assign sub_operand = ~{1'b0, d_q};

   // shifted - divisor as shifted + ~divisor + 1; carry out means no borrow.
   div_seq_adder #(
      .W (N + 1)
   ) u_trial_sub (
      .a_i    (shifted),
      .b_i    (sub_operand),
      .cin_i  (1'b1),
      .sum_o  (trial),
      .cout_o (no_borrow)
   );

   always_comb begin
      state_d     = state_q;
      q_d         = q_q;
      r_d         = r_q;
      d_d         = d_q;
      count_d     = count_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  q_d     = dividend;
                  r_d     = '0;
                  d_d     = divisor;
                  count_d = COUNT_LOAD;
                  dbz_d   = 1'b0;
                  state_d = ST_RUN;
               end else begin
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
                  state_d     = ST_DONE;
               end
            end
         end

         ST_RUN: begin
            r_d     = no_borrow ? trial : shifted;
            q_d     = {q_q[N-2:0], no_borrow};
            count_d = count_q - COUNT_LAST;
            if (count_q == COUNT_LAST) begin
               // Results are captured from the final iteration's outcome so
               // they appear together with done, never partially.
               quotient_d  = q_d;
               remainder_d = r_d[N-1:0];
               state_d     = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status flags are registered from the next state so they line up
      // with the state register without a decode after the flops.
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         q_q         <= '0;
         r_q         <= '0;
         d_q         <= '0;
         count_q     <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         q_q         <= q_d;
         r_q         <= r_d;
         d_q         <= d_d;
         count_q     <= count_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
// Drives an N=8 and an N=4 divider. A transaction-level model (elapsed cycles
// since an accepted start, results from / and %) predicts every output each
// cycle; directed operations additionally check hand-computed literals.
// -----------------------------------------------------------------------------
module tb_div_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Index 0: N=8 instance, index 1: N=4 instance.
   logic       rst_s   [2];
   logic       start_s [2];
   logic [7:0] a_s     [2];
   logic [7:0] b_s     [2];
   logic       busy_s  [2];
   logic       done_s  [2];
   logic       dbz_s   [2];
   logic [7:0] q_s     [2];
   logic [7:0] r_s     [2];

   logic       busy8, done8, dbz8, busy4, done4, dbz4;
   logic [7:0] q8, r8;
   logic [3:0] q4, r4;

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  chk_en   = 1'b0;

   div_seq #(.N(8)) dut8 (
      .clk         (clk),
      .rst         (rst_s[0]),
      .start       (start_s[0]),
      .dividend    (a_s[0]),
      .divisor     (b_s[0]),
      .busy        (busy8),
      .done        (done8),
      .quotient    (q8),
      .remainder   (r8),
      .div_by_zero (dbz8)
   );

   div_seq #(.N(4)) dut4 (
      .clk         (clk),
      .rst         (rst_s[1]),
      .start       (start_s[1]),
      .dividend    (a_s[1][3:0]),
      .divisor     (b_s[1][3:0]),
      .busy        (busy4),
      .done        (done4),
      .quotient    (q4),
      .remainder   (r4),
      .div_by_zero (dbz4)
   );

   assign busy_s[0] = busy8;
   assign done_s[0] = done8;
   assign dbz_s[0]  = dbz8;
   assign q_s[0]    = q8;
   assign r_s[0]    = r8;
   assign busy_s[1] = busy4;
   assign done_s[1] = done4;
   assign dbz_s[1]  = dbz4;
   assign q_s[1]    = {4'b0000, q4};
   assign r_s[1]    = {4'b0000, r4};

   function automatic logic [7:0] mask_of(input int i);
      return (i == 0) ? 8'hFF : 8'h0F;
   endfunction

   function automatic int width_of(input int i);
      return (i == 0) ? 8 : 4;
   endfunction

   function automatic void chk(input string name, input int i,
                               input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d actual=%0d required=%0d at %0t", name, i, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   // m_el: cycles elapsed since the accepted start (0 = idle); m_lat: cycle
   // in which done is due. Results become visible in the done cycle.
   int         m_el    [2] = '{0, 0};
   int         m_lat   [2] = '{0, 0};
   int         m_acc   [2] = '{0, 0};
   logic [7:0] m_q     [2] = '{8'd0, 8'd0};
   logic [7:0] m_r     [2] = '{8'd0, 8'd0};
   logic [7:0] pend_q  [2] = '{8'd0, 8'd0};
   logic [7:0] pend_r  [2] = '{8'd0, 8'd0};
   logic       m_dbz   [2] = '{1'b0, 1'b0};

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst_s[i]) begin
            m_el[i]  <= 0;
            m_lat[i] <= 0;
            m_q[i]   <= 8'd0;
            m_r[i]   <= 8'd0;
            m_dbz[i] <= 1'b0;
         end else if (m_el[i] == 0) begin
            if (start_s[i]) begin
               m_acc[i] <= m_acc[i] + 1;
               m_el[i]  <= 1;
               if (b_s[i] == 8'd0) begin
                  m_lat[i] <= 1;
                  m_dbz[i] <= 1'b1;
                  m_q[i]   <= mask_of(i);
                  m_r[i]   <= a_s[i];
               end else begin
                  m_lat[i]  <= width_of(i) + 1;
                  m_dbz[i]  <= 1'b0;
                  pend_q[i] <= a_s[i] / b_s[i];
                  pend_r[i] <= a_s[i] % b_s[i];
               end
            end
         end else if (m_el[i] == m_lat[i]) begin
            m_el[i] <= 0;
         end else begin
            m_el[i] <= m_el[i] + 1;
            if (m_el[i] + 1 == m_lat[i]) begin
               m_q[i] <= pend_q[i];
               m_r[i] <= pend_r[i];
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk("busy", i, 32'(busy_s[i]), 32'(m_el[i] != 0));
            chk("done", i, 32'(done_s[i]), 32'(m_el[i] != 0 && m_el[i] == m_lat[i]));
            chk("div_by_zero", i, 32'(dbz_s[i]), 32'(m_dbz[i]));
            // Mid-operation result values are not part of the contract.
            if (m_el[i] == 0 || m_el[i] == m_lat[i]) begin
               chk("quotient", i, 32'(q_s[i]), 32'(m_q[i]));
               chk("remainder", i, 32'(r_s[i]), 32'(m_r[i]));
            end
         end
      end
   end

   // ---------------- directed operation ----------------
   // poke_cyc: cycle in which a stray 9/3 start is pulsed (0 = never).
   // rst_cyc : cycle in which rst is held for one edge (0 = never).
   task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b,
                         input int poke_cyc, input int rst_cyc,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edbz, input int elat);
      int cyc;
      int w;
      bit did_rst;
      w = 0;
      did_rst = 1'b0;
      while (busy_s[i] && w < 50) begin
         @(negedge clk);
         w++;
      end
      a_s[i]     = a;
      b_s[i]     = b;
      start_s[i] = 1'b1;
      @(negedge clk);
      start_s[i] = 1'b0;
      cyc = 1;
      while (cyc < 40) begin
         if (done_s[i]) break;
         chk("busy_in_run", i, 32'(busy_s[i]), 32'd1);
         if (cyc == poke_cyc) begin
            start_s[i] = 1'b1;
            a_s[i]     = 8'd9;
            b_s[i]     = 8'd3;
         end
         if (cyc == rst_cyc) rst_s[i] = 1'b1;
         @(negedge clk);
         cyc++;
         start_s[i] = 1'b0;
         if (rst_s[i]) begin
            rst_s[i] = 1'b0;
            did_rst  = 1'b1;
            break;
         end
      end
      if (did_rst) begin
         chk("rst_busy", i, 32'(busy_s[i]), 32'd0);
         chk("rst_done", i, 32'(done_s[i]), 32'd0);
         chk("rst_quotient", i, 32'(q_s[i]), 32'd0);
         chk("rst_remainder", i, 32'(r_s[i]), 32'd0);
         chk("rst_dbz", i, 32'(dbz_s[i]), 32'd0);
         for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rst_no_done", i, 32'(done_s[i]), 32'd0);
         end
         $display("op dut%0d %0d/%0d aborted by rst at cycle %0d", i, a, b, rst_cyc);
      end else begin
         chk("done_seen", i, 32'(done_s[i]), 32'd1);
         chk("latency", i, 32'(cyc), 32'(elat));
         chk("lit_quotient", i, 32'(q_s[i]), 32'(eq));
         chk("lit_remainder", i, 32'(r_s[i]), 32'(er));
         chk("lit_dbz", i, 32'(dbz_s[i]), 32'(edbz));
         chk("model_quotient", i, 32'(m_q[i]), 32'(eq));
         chk("model_remainder", i, 32'(m_r[i]), 32'(er));
         $display("op dut%0d %0d/%0d -> q=%0d r=%0d dbz=%0d latency=%0d",
                  i, a, b, q_s[i], r_s[i], dbz_s[i], cyc);
      end
   endtask

   // ---------------- randomized traffic ----------------
   function automatic logic [7:0] rand_val(input int i);
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) return 8'd0;
      if (sel == 1) return mask_of(i);
      return 8'($urandom) & mask_of(i);
   endfunction

   task automatic rand_run(input int i);
      int guard;
      guard = 0;
      while (m_acc[i] < 1000 && guard < 40000) begin
         @(negedge clk);
         guard++;
         start_s[i] = ($urandom_range(0, 3) != 0);
         a_s[i]     = rand_val(i);
         b_s[i]     = ($urandom_range(0, 9) == 0) ? 8'd0 : rand_val(i);
         rst_s[i]   = ($urandom_range(0, 499) == 0);
      end
      @(negedge clk);
      start_s[i] = 1'b0;
      rst_s[i]   = 1'b0;
      chk("rand_ops_reached", i, 32'(m_acc[i] >= 1000), 32'd1);
      $display("random dut%0d accepted=%0d cycles=%0d", i, m_acc[i], guard);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_s[i]   = 1'b1;
         start_s[i] = 1'b0;
         a_s[i]     = 8'd0;
         b_s[i]     = 8'd0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("reset_busy", i, 32'(busy_s[i]), 32'd0);
         chk("reset_done", i, 32'(done_s[i]), 32'd0);
         chk("reset_quotient", i, 32'(q_s[i]), 32'd0);
         chk("reset_remainder", i, 32'(r_s[i]), 32'd0);
         chk("reset_dbz", i, 32'(dbz_s[i]), 32'd0);
         rst_s[i] = 1'b0;
      end
      chk_en = 1'b1;
      @(negedge clk);

      // N=8 directed
      run_op(0, 8'd100, 8'd7,   0, 0, 8'd14,  8'd2, 1'b0, 9);
      run_op(0, 8'd255, 8'd1,   0, 0, 8'd255, 8'd0, 1'b0, 9);
      run_op(0, 8'd3,   8'd200, 0, 0, 8'd0,   8'd3, 1'b0, 9);
      run_op(0, 8'd5,   8'd0,   0, 0, 8'd255, 8'd5, 1'b1, 1);
      run_op(0, 8'd9,   8'd3,   0, 0, 8'd3,   8'd0, 1'b0, 9);
      run_op(0, 8'd100, 8'd7,   4, 0, 8'd14,  8'd2, 1'b0, 9);
      run_op(0, 8'd9,   8'd3,   0, 0, 8'd3,   8'd0, 1'b0, 9);
      run_op(0, 8'd200, 8'd9,   0, 5, 8'd0,   8'd0, 1'b0, 0);
      run_op(0, 8'd200, 8'd9,   0, 0, 8'd22,  8'd2, 1'b0, 9);

      // N=4 directed
      run_op(1, 8'd15,  8'd4,   0, 0, 8'd3,   8'd3, 1'b0, 5);
      run_op(1, 8'd7,   8'd0,   0, 0, 8'd15,  8'd7, 1'b1, 1);
      run_op(1, 8'd1,   8'd15,  0, 0, 8'd0,   8'd1, 1'b0, 5);

      fork
         rand_run(0);
         rand_run(1);
      join

      repeat (12) @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
